alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning cycles operands are held on the ALU before the result is sampled (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each, requester has an operation pending.
REQ-005 SHALL have ports req0_num/req1_num, input, 8 each, operand from each requester.
REQ-006 SHALL have ports req0_op/req1_op, input, 3 each, ALU opcode from each requester (passed through unmodified).
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each, the operation is accepted this cycle.
REQ-008 SHALL have ports alu_num (output, 8), alu_op (output, 3) and alu_result (input, 32), the interface to the shared ALU.
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1, winning requester index), rsp_data (output, 32) and rsp_ready (input, 1).
REQ-010 SHALL have ports disp_result (output, 32, last completed result for the seven-segment display) and busy (output, 1).

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE and RESP; busy SHALL be 1 in ISSUE and RESP.
REQ-012 In IDLE, SHALL assert exactly one of req0_ready/req1_ready combinationally, only for a requester whose valid is high, chosen by round-robin.
REQ-013 Round-robin: when both valids are high, SHALL grant the requester not granted last; when one is high, SHALL grant it regardless of history.
REQ-014 A transfer SHALL occur when valid and ready are both high; on that edge SHALL register num, op and the requester index, and move IDLE -> ISSUE.
REQ-015 SHALL drive alu_num/alu_op from the registered operands during ISSUE and RESP, and drive 0 in IDLE.
REQ-016 SHALL remain in ISSUE for exactly ALU_LAT cycles, then capture alu_result into rsp_data and disp_result and move to RESP.
REQ-017 Latency: for a transfer on edge N, rsp_valid SHALL first be high in the cycle after edge N+ALU_LAT.
REQ-018 In RESP, SHALL hold rsp_valid, rsp_id and rsp_data stable until rsp_ready is high, then return to IDLE on that edge.
REQ-019 No new request SHALL be accepted in ISSUE or RESP; both ready outputs SHALL be 0 there.
REQ-020 disp_result SHALL hold its value until the next capture and SHALL NOT change on the RESP -> IDLE transition.
REQ-021 Requester valid changes after acceptance SHALL have no effect on the operation in flight.
REQ-022 The last-grant pointer SHALL update only on a transfer.

Reset
REQ-023 On a clock edge with reset high, SHALL enter IDLE from any state, abandoning any in-flight operation without producing a response.
REQ-024 Reset values SHALL be: rsp_valid 0, rsp_id 0, rsp_data 0, disp_result 0, busy 0, alu_num 0, alu_op 0, and a last-grant pointer of 1 (so req0 wins the first tie).
REQ-025 req0_ready/req1_ready SHALL be 0 during any cycle in which reset is high.

Structure
REQ-026 Package alu_arb_pkg SHALL hold the state enum and the constants NUM_W=8, OP_W=3 and RES_W=32.
REQ-027 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: two valids and the last-grant pointer; output: a one-hot grant).

Verification
REQ-028 Single request: req0 sends num=8'h05, op=3'd0, ALU_LAT=1, model returns 32'h0000000A, rsp_ready=1 -> rsp_valid high 2 cycles after acceptance, rsp_id=0, rsp_data=32'h0000000A, disp_result=32'h0000000A.
REQ-029 Tie fairness: both valids held high for 4 operations -> grant order 0,1,0,1, with no ready asserted while busy.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable for 5 cycles, no new grant; release -> IDLE next cycle.
REQ-031 Latency: ALU_LAT=3 -> alu_num/alu_op stable for 3 ISSUE cycles; rsp_valid first high 4 cycles after acceptance.
REQ-032 Reset mid-ISSUE: reset asserted in the 1st ISSUE cycle -> next cycle IDLE, rsp_valid=0, disp_result=0, and req0 wins the next tie.
REQ-033 Lone requester: only req1_valid high for 3 operations -> req1 is granted all 3 times, regardless of last-grant history.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
//   state_e : arbiter FSM states
//   NUM_W   : operand width
//   OP_W    : opcode width
//   RES_W   : ALU result width
package alu_arb_pkg;

    localparam int NUM_W = 8;
    localparam int OP_W  = 3;
    localparam int RES_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of every non-clock signal of the ALU arbiter.
//   slave  : arbiter side (takes requests, drives ALU operands and the response)
//   master : environment side (requesters, shared ALU, response consumer)
// Signals:
//   req0_*/req1_* : valid/num/op from each requester, ready back to each
//   alu_num/alu_op/alu_result : shared ALU port
//   rsp_valid/rsp_id/rsp_data/rsp_ready : response handshake
//   disp_result : last completed result, busy : operation in flight
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic             req0_valid;
    logic [NUM_W-1:0] req0_num;
    logic [OP_W-1:0]  req0_op;
    logic             req0_ready;
    logic             req1_valid;
    logic [NUM_W-1:0] req1_num;
    logic [OP_W-1:0]  req1_op;
    logic             req1_ready;
    logic [NUM_W-1:0] alu_num;
    logic [OP_W-1:0]  alu_op;
    logic [RES_W-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_data;
    logic             rsp_ready;
    logic [RES_W-1:0] disp_result;
    logic             busy;

    modport slave (
        input  req0_valid, req0_num, req0_op, req1_valid, req1_num, req1_op,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready, alu_num, alu_op,
        output rsp_valid, rsp_id, rsp_data, disp_result, busy
    );

    modport master (
        output req0_valid, req0_num, req0_op, req1_valid, req1_num, req1_op,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready, alu_num, alu_op,
        input  rsp_valid, rsp_id, rsp_data, disp_result, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   i_valid[1:0] : request lines (bit 0 = requester 0)
//   i_last       : index of the requester granted most recently
//   o_grant[1:0] : one-hot grant, zero when nobody requests
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        // On a tie the requester that did not win last time takes it.
        if (i_valid == 2'b11) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. A granted operation is held on the
// ALU for ALU_LAT cycles, its result is captured and offered as a response
// until consumed, then the arbiter returns to IDLE.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_arbiter_if.slave (requests, ALU port, response, display, busy)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = 4;

    state_e           r_state;
    state_e           w_state_next;
    logic [NUM_W-1:0] r_num;
    logic [OP_W-1:0]  r_op;
    logic             r_id;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [RES_W-1:0] r_result;

    logic [1:0]       w_grant;
    logic             w_can_grant;
    logic             w_xfer;
    logic             w_issue_done;

    rr_arb2 u_rr_arb2 (
        .i_valid ({bus.req1_valid, bus.req0_valid}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // Grants are only visible in IDLE and never while reset is being applied.
    assign w_can_grant  = (r_state == IDLE) && !reset;
    assign w_xfer       = w_can_grant && (w_grant != 2'b00);
    assign w_issue_done = (r_state == ISSUE) && (r_cnt == CNT_W'(ALU_LAT - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_xfer)        w_state_next = ISSUE;
            ISSUE:   if (w_issue_done)  w_state_next = RESP;
            RESP:    if (bus.rsp_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_num    <= '0;
            r_op     <= '0;
            r_id     <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer) begin
                r_num  <= w_grant[1] ? bus.req1_num : bus.req0_num;
                r_op   <= w_grant[1] ? bus.req1_op  : bus.req0_op;
                r_id   <= w_grant[1];
                r_last <= w_grant[1];
                r_cnt  <= '0;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // One register feeds both the response and the display: they are
            // captured together and the display must outlive the response.
            if (w_issue_done) begin
                r_result <= bus.alu_result;
            end
        end
    end

    assign bus.req0_ready  = w_can_grant && w_grant[0];
    assign bus.req1_ready  = w_can_grant && w_grant[1];
    assign bus.alu_num     = (r_state == IDLE) ? '0 : r_num;
    assign bus.alu_op      = (r_state == IDLE) ? '0 : r_op;
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.rsp_id      = r_id;
    assign bus.rsp_data    = r_result;
    assign bus.disp_result = r_result;
    assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) share one
// stimulus. A transaction-level model checks both every cycle; directed
// scenarios add hand-computed literal expectations.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       v0, v1, rr;
    logic [7:0] n0, n1;
    logic [2:0] o0, o1;

    alu_arbiter_if if1 ();
    alu_arbiter_if if3 ();

    alu_arbiter #(.ALU_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    alu_arbiter #(.ALU_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    // Stand-in ALU.
    function automatic logic [31:0] alu_f(input logic [7:0] n, input logic [2:0] op);
        case (op)
            3'd0:    return {23'd0, n, 1'b0};
            3'd1:    return 32'(n) + 32'd1;
            3'd2:    return {24'd0, ~n};
            default: return {8'hA5, 13'd0, op, n};
        endcase
    endfunction

    assign if1.req0_valid = v0;  assign if3.req0_valid = v0;
    assign if1.req0_num   = n0;  assign if3.req0_num   = n0;
    assign if1.req0_op    = o0;  assign if3.req0_op    = o0;
    assign if1.req1_valid = v1;  assign if3.req1_valid = v1;
    assign if1.req1_num   = n1;  assign if3.req1_num   = n1;
    assign if1.req1_op    = o1;  assign if3.req1_op    = o1;
    assign if1.rsp_ready  = rr;  assign if3.rsp_ready  = rr;
    assign if1.alu_result = alu_f(if1.alu_num, if1.alu_op);
    assign if3.alu_result = alu_f(if3.alu_num, if3.alu_op);

    // Per-instance output views: index 0 = ALU_LAT 1, index 1 = ALU_LAT 3.
    logic        a_r0 [2], a_r1 [2], a_busy [2], a_rv [2], a_id [2];
    logic [7:0]  a_an [2];
    logic [2:0]  a_ao [2];
    logic [31:0] a_disp [2], a_data [2];
    assign a_r0[0] = if1.req0_ready;    assign a_r0[1] = if3.req0_ready;
    assign a_r1[0] = if1.req1_ready;    assign a_r1[1] = if3.req1_ready;
    assign a_busy[0] = if1.busy;        assign a_busy[1] = if3.busy;
    assign a_rv[0] = if1.rsp_valid;     assign a_rv[1] = if3.rsp_valid;
    assign a_id[0] = if1.rsp_id;        assign a_id[1] = if3.rsp_id;
    assign a_an[0] = if1.alu_num;       assign a_an[1] = if3.alu_num;
    assign a_ao[0] = if1.alu_op;        assign a_ao[1] = if3.alu_op;
    assign a_disp[0] = if1.disp_result; assign a_disp[1] = if3.disp_result;
    assign a_data[0] = if1.rsp_data;    assign a_data[1] = if3.rsp_data;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    // An accepted operation is "age" cycles old; it occupies the ALU while
    // age <= latency and is offered as a response afterwards.
    int          lat [2] = '{1, 3};
    logic        m_ok [2] = '{1'b0, 1'b0};
    logic        m_act [2], m_id [2], m_last [2];
    logic [7:0]  m_num [2];
    logic [2:0]  m_op [2];
    int          m_age [2];
    logic [31:0] m_disp [2];

    task automatic model_cycle(input int j);
        logic [1:0]  g;
        logic        e_busy, e_rv;
        logic [7:0]  e_an;
        logic [2:0]  e_ao;
        logic [31:0] e_res;
        logic [79:0] exp_v, act_v;
        g = 2'b00;
        e_busy = 1'b0; e_rv = 1'b0; e_an = 8'd0; e_ao = 3'd0;
        e_res = alu_f(m_num[j], m_op[j]);
        if (!m_act[j]) begin
            if (reset)           g = 2'b00;
            else if (v0 && v1)   g = m_last[j] ? 2'b01 : 2'b10;
            else                 g = {v1, v0};
        end else begin
            e_busy = 1'b1;
            e_an   = m_num[j];
            e_ao   = m_op[j];
            e_rv   = (m_age[j] > lat[j]);
        end
        if (m_ok[j]) begin
            exp_v = {g[0], g[1], e_busy, e_rv, e_an, e_ao, m_disp[j],
                     e_rv ? m_id[j] : 1'b0, e_rv ? e_res : 32'd0};
            act_v = {a_r0[j], a_r1[j], a_busy[j], a_rv[j], a_an[j], a_ao[j], a_disp[j],
                     e_rv ? a_id[j] : 1'b0, e_rv ? a_data[j] : 32'd0};
            check(j == 0 ? "model lat1" : "model lat3", 128'(act_v), 128'(exp_v));
        end
        // advance to the next cycle
        if (reset) begin
            m_ok[j] = 1'b1; m_act[j] = 1'b0; m_last[j] = 1'b1; m_disp[j] = 32'd0;
            m_num[j] = 8'd0; m_op[j] = 3'd0; m_id[j] = 1'b0; m_age[j] = 0;
        end else if (!m_act[j]) begin
            if (g != 2'b00) begin
                m_act[j] = 1'b1; m_age[j] = 1; m_id[j] = g[1]; m_last[j] = g[1];
                m_num[j] = g[1] ? n1 : n0;
                m_op[j]  = g[1] ? o1 : o0;
            end
        end else if (m_age[j] <= lat[j]) begin
            if (m_age[j] == lat[j]) m_disp[j] = e_res;
            m_age[j]++;
        end else if (rr) begin
            m_act[j] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0);
        model_cycle(1);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (a_busy[0] === 1'b0 && a_busy[1] === 1'b0) break;
        end
        check("wait idle", 128'(k < 200), 128'(1));
    endtask

    int gq[$];

    initial begin
        int k;
        reset = 1'b1; v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
        n0 = 8'd0; n1 = 8'd0; o0 = 3'd0; o1 = 3'd0;

        // Ready stays low while reset is high even with both valids up.
        @(negedge clk);
        check("ready in reset", 128'({a_r0[0], a_r1[0], a_r0[1], a_r1[1]}), 128'(0));
        tick(); v0 = 1'b0; v1 = 1'b0;
        tick(); tick(); reset = 1'b0;

        @(negedge clk);
        check("reset rsp_valid", 128'(a_rv[0]), 128'(0));
        check("reset rsp_id", 128'(a_id[0]), 128'(0));
        check("reset rsp_data", 128'(a_data[0]), 128'(0));
        check("reset disp", 128'(a_disp[0]), 128'(0));
        check("reset busy", 128'(a_busy[0]), 128'(0));
        check("reset alu", 128'({a_an[0], a_ao[0]}), 128'(0));

        // Tie fairness: four grants on the ALU_LAT=1 instance alternate from req0.
        tick(); n0 = 8'h11; o0 = 3'd1; n1 = 8'h22; o1 = 3'd2; v0 = 1'b1; v1 = 1'b1;
        gq.delete();
        for (k = 0; k < 200 && gq.size() < 4; k++) begin
            @(negedge clk);
            if (a_busy[0] === 1'b1)
                check("tie ready while busy", 128'({a_r0[0], a_r1[0]}), 128'(0));
            if (a_r0[0] === 1'b1) gq.push_back(0);
            if (a_r1[0] === 1'b1) gq.push_back(1);
        end
        tick(); v0 = 1'b0; v1 = 1'b0;
        check("tie grant count", 128'(gq.size()), 128'(4));
        if (gq.size() == 4) begin
            check("tie grant order", 128'({gq[0][1:0], gq[1][1:0], gq[2][1:0], gq[3][1:0]}),
                  128'(8'b00_01_00_01));
        end
        wait_idle();

        // Single request, ALU_LAT=1: response two cycles after acceptance.
        tick(); n0 = 8'h05; o0 = 3'd0; v0 = 1'b1;
        @(negedge clk);
        check("single grant", 128'({a_r0[0], a_r1[0]}), 128'(2'b10));
        tick(); v0 = 1'b0;
        @(negedge clk);
        check("single rsp early", 128'(a_rv[0]), 128'(0));
        @(negedge clk);
        check("single rsp_valid", 128'(a_rv[0]), 128'(1));
        check("single rsp_id", 128'(a_id[0]), 128'(0));
        check("single rsp_data", 128'(a_data[0]), 128'(32'h0000000A));
        check("single disp", 128'(a_disp[0]), 128'(32'h0000000A));
        wait_idle();
        check("disp holds in idle", 128'(a_disp[0]), 128'(32'h0000000A));

        // Backpressure: response held for five cycles, pending req1 not granted.
        tick(); rr = 1'b0; n0 = 8'h33; o0 = 3'd1; v0 = 1'b1;
        @(negedge clk);
        check("bp grant", 128'(a_r0[0]), 128'(1));
        tick(); v0 = 1'b0; v1 = 1'b1; n1 = 8'h10; o1 = 3'd2;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (a_rv[0] === 1'b1) break;
        end
        check("bp rsp reached", 128'(k < 50), 128'(1));
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check("bp hold", 128'({a_rv[0], a_data[0], a_r1[0]}), 128'({1'b1, 32'h34, 1'b0}));
        end
        tick(); rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp release idle", 128'({a_busy[0], a_r1[0]}), 128'(2'b01));
        tick(); v1 = 1'b0;
        wait_idle();

        // Latency on the ALU_LAT=3 instance.
        tick(); n0 = 8'h7F; o0 = 3'd3; v0 = 1'b1;
        @(negedge clk);
        check("lat grant", 128'(a_r0[1]), 128'(1));
        tick(); v0 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                check("lat issue hold", 128'({a_an[1], a_ao[1], a_rv[1]}),
                      128'({8'h7F, 3'd3, 1'b0}));
            end else begin
                check("lat rsp", 128'({a_rv[1], a_data[1]}), 128'({1'b1, 32'hA500037F}));
            end
        end
        wait_idle();

        // Reset in the first ISSUE cycle abandons the operation.
        tick(); n0 = 8'h21; o0 = 3'd0; v0 = 1'b1;
        @(negedge clk);
        check("rst grant", 128'(a_r0[0]), 128'(1));
        tick(); v0 = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rst in issue", 128'({a_busy[0], a_r0[0], a_r1[0]}), 128'(3'b100));
        tick(); reset = 1'b0; v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        check("rst after", 128'({a_busy[0], a_rv[0], a_disp[0]}), 128'(0));
        check("rst tie winner", 128'({a_r0[0], a_r1[0]}), 128'(2'b10));
        tick(); v0 = 1'b0; v1 = 1'b0;
        wait_idle();

        // Lone requester 1 wins every time.
        tick(); n1 = 8'h40; o1 = 3'd0; v1 = 1'b1;
        gq.delete();
        for (k = 0; k < 200 && gq.size() < 3; k++) begin
            @(negedge clk);
            if (a_r0[0] === 1'b1) gq.push_back(0);
            if (a_r1[0] === 1'b1) gq.push_back(1);
        end
        tick(); v1 = 1'b0;
        check("lone grant count", 128'(gq.size()), 128'(3));
        foreach (gq[i]) check("lone grant id", 128'(gq[i]), 128'(1));
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
